// File: rtl/obstacle_scheduler_if.sv
// Signal bundle between the obstacle scheduler and its consumers
// (controller input, renderer, box-collision logic).
interface obstacle_scheduler_if;
  logic        replay_btn;
  logic        collision;
  logic [43:0] obs_x;
  logic [3:0]  speed;
  logic        tick;
  logic [1:0]  anim_phase;
  logic        running;
  logic        game_over;
  logic [15:0] score;

  modport master (
    input  replay_btn, collision,
    output obs_x, speed, tick, anim_phase, running, game_over, score
  );

  modport slave (
    output replay_btn, collision,
    input  obs_x, speed, tick, anim_phase, running, game_over, score
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Dino Run game sequencer: IDLE/RUN/OVER control, motion tick, obstacle
// positions with speed ramp and spaced pseudo-random respawn.
module obstacle_scheduler #(
  parameter int HACTIVE         = 1280,
  parameter int TICK_CYCLES     = 2000000,
  parameter int MIN_GAP         = 256,
  parameter int PASSES_PER_STEP = 12,
  parameter int SPEED_MAX       = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  obstacle_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

  localparam int              CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [3:0]      SPEED_TOP = 4'(SPEED_MAX);
  localparam logic [4:0]      PASS_STEP = 5'(PASSES_PER_STEP);
  localparam logic [5:0]      LFSR_SEED = 6'b101011;
  localparam logic [10:0]     X_LIMIT   = 11'd2047;

  function automatic logic [10:0] init_x(input int i);
    case (i)
      0:       return 11'd1200;
      1:       return 11'd1600;
      2:       return 11'd1800;
      default: return 11'd1400;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [10:0]   x_q [4];
  logic [10:0]   x_d [4];
  logic [3:0]    speed_q, speed_d;
  logic [3:0]    pass_q, pass_d;
  logic [15:0]   score_q, score_d;
  logic [1:0]    anim_q, anim_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    lfsr_q, lfsr_d;
  logic [2:0]    sync_q;
  logic          press;
  logic          tick;

  logic [10:0]   moved [4];
  logic [2:0]    n_exp;
  logic          resp_valid;
  logic [1:0]    resp_idx;
  logic [10:0]   far;
  logic [11:0]   cand, gap, pick;
  logic [4:0]    pass_sum;
  logic [16:0]   score_sum;

  // Two synchronizer flops, the third holds the previous sample for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], bus.replay_btn};
  end

  assign press = sync_q[1] & ~sync_q[2];
  assign tick  = (state_q == RUN) && (cnt_q == TICK_LAST);

  // Motion and respawn candidates, all derived from the pre-tick positions.
  always_comb begin
    n_exp = '0;
    for (int i = 0; i < 4; i++) begin
      if (x_q[i] > {7'd0, speed_q}) begin
        moved[i] = x_q[i] - {7'd0, speed_q};
      end else begin
        moved[i] = '0;
        if (x_q[i] != '0) n_exp = n_exp + 3'd1;
      end
    end
    resp_valid = 1'b0;
    resp_idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      if (x_q[i] == '0) begin
        resp_valid = 1'b1;
        resp_idx   = 2'(i);
      end
    end
    far = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != resp_idx && moved[i] > far) far = moved[i];
    end
    cand      = 12'(HACTIVE) + {3'd0, lfsr_q[5:1], 4'd0};
    gap       = {1'b0, far} + 12'(MIN_GAP);
    pick      = (gap > cand) ? gap : cand;
    pass_sum  = {1'b0, pass_q} + {2'd0, n_exp};
    score_sum = {1'b0, score_q} + {14'd0, n_exp};
  end

  // NOTE: every next-state variable gets its hold value first so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    speed_d = speed_q;
    pass_d  = pass_q;
    score_d = score_q;
    anim_d  = anim_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;

    case (state_q)
      IDLE, OVER: begin
        if (press) begin
          state_d = RUN;
          for (int i = 0; i < 4; i++) x_d[i] = init_x(i);
          speed_d = 4'd1;
          pass_d  = '0;
          score_d = '0;
          anim_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bus.collision) begin
          state_d = OVER;
        end else if (tick) begin
          cnt_d = '0;
          for (int i = 0; i < 4; i++) x_d[i] = moved[i];
          if (resp_valid) x_d[resp_idx] = pick[11] ? X_LIMIT : pick[10:0];
          lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
          anim_d = anim_q + 2'd1;
          if (pass_sum >= PASS_STEP) begin
            pass_d = 4'(pass_sum - PASS_STEP);
            if (speed_q < SPEED_TOP) speed_d = speed_q + 4'd1;
          end else begin
            pass_d = pass_sum[3:0];
          end
          score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      // NOTE: the position array is four flop words, not a RAM, so it is reset.
      for (int i = 0; i < 4; i++) x_q[i] <= init_x(i);
      speed_q <= 4'd1;
      pass_q  <= '0;
      score_q <= '0;
      anim_q  <= '0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) x_q[i] <= x_d[i];
      speed_q <= speed_d;
      pass_q  <= pass_d;
      score_q <= score_d;
      anim_q  <= anim_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign bus.obs_x      = {x_q[3], x_q[2], x_q[1], x_q[0]};
  assign bus.speed      = speed_q;
  assign bus.tick       = tick;
  assign bus.anim_phase = anim_q;
  assign bus.running    = (state_q == RUN);
  assign bus.game_over  = (state_q == OVER);
  assign bus.score      = score_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with a short motion tick; a small
// game model tracks positions, speed and score through the long ramp run.
module tb_obstacle_scheduler;

  localparam int HACTIVE = 1280;
  localparam int MIN_GAP = 256;

  logic clk;
  logic reset_n;
  obstacle_scheduler_if bus ();

  obstacle_scheduler #(
    .HACTIVE(HACTIVE), .TICK_CYCLES(4), .MIN_GAP(MIN_GAP),
    .PASSES_PER_STEP(12), .SPEED_MAX(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          mx [4];
  int          mspeed, mpass, mscore, manim;
  logic [5:0]  mlfsr;
  int          tick_cyc;
  logic [43:0] init_obs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    mx[0] = 1200; mx[1] = 1600; mx[2] = 1800; mx[3] = 1400;
    mspeed = 1; mpass = 0; mscore = 0; manim = 0;
  endtask

  function automatic logic [43:0] model_obs();
    return {11'(mx[3]), 11'(mx[2]), 11'(mx[1]), 11'(mx[0])};
  endfunction

  task automatic model_tick(output int nexp);
    int moved [4];
    int ridx, far, pos;
    ridx = -1;
    nexp = 0;
    for (int i = 0; i < 4; i++) begin
      if (mx[i] == 0 && ridx < 0) ridx = i;
      if (mx[i] > mspeed) moved[i] = mx[i] - mspeed;
      else begin
        moved[i] = 0;
        if (mx[i] != 0) nexp++;
      end
    end
    if (ridx >= 0) begin
      far = 0;
      for (int i = 0; i < 4; i++) if (i != ridx && moved[i] > far) far = moved[i];
      pos = HACTIVE + 16 * int'(mlfsr[5:1]);
      if (far + MIN_GAP > pos) pos = far + MIN_GAP;
      if (pos > 2047) pos = 2047;
      moved[ridx] = pos;
    end
    for (int i = 0; i < 4; i++) mx[i] = moved[i];
    mlfsr  = {mlfsr[4:0], mlfsr[5] ^ mlfsr[4]};
    manim  = (manim + 1) % 4;
    mscore = (mscore + nexp > 65535) ? 65535 : mscore + nexp;
    mpass += nexp;
    if (mpass >= 12) begin
      mpass -= 12;
      if (mspeed < 8) mspeed++;
    end
  endtask

  // Waits (bounded) for a tick pulse, then steps to the negedge after it is applied.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (bus.tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(bus.tick), 64'(1));
    tick_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic model_step(input string tag, output int nexp);
    wait_tick(tag);
    model_tick(nexp);
    check({tag, "_obs"},   64'(bus.obs_x), 64'(model_obs()));
    check({tag, "_speed"}, 64'(bus.speed), 64'(mspeed));
    check({tag, "_score"}, 64'(bus.score), 64'(mscore));
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 200000 cycles");
    $fatal(1, "watchdog");
  end

  int n, t1, ticks_seen, flags_seen, bad, k, nt, exp_at_max;
  bit first12_done, was_max;

  initial begin
    init_obs       = {11'd1400, 11'd1800, 11'd1600, 11'd1200};
    reset_n        = 1'b0;
    bus.replay_btn = 1'b0;
    bus.collision  = 1'b0;
    model_init();
    mlfsr = 6'b101011;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_obs_x",     64'(bus.obs_x),      64'(init_obs));
    check("rst_speed",     64'(bus.speed),      64'(1));
    check("rst_tick",      64'(bus.tick),       64'(0));
    check("rst_anim",      64'(bus.anim_phase), 64'(0));
    check("rst_running",   64'(bus.running),    64'(0));
    check("rst_game_over", 64'(bus.game_over),  64'(0));
    check("rst_score",     64'(bus.score),      64'(0));

    // Idle for 100 cycles, with a collision burst that must be ignored
    reset_n    = 1'b1;
    ticks_seen = 0;
    flags_seen = 0;
    for (int i = 0; i < 100; i++) begin
      bus.collision = (i >= 40 && i < 45);
      @(negedge clk);
      if (bus.tick === 1'b1) ticks_seen++;
      if (bus.running !== 1'b0 || bus.game_over !== 1'b0) flags_seen++;
    end
    bus.collision = 1'b0;
    check("idle_ticks", 64'(ticks_seen), 64'(0));
    check("idle_flags", 64'(flags_seen), 64'(0));
    check("idle_obs_x", 64'(bus.obs_x),  64'(init_obs));

    // Press: RUN on the third edge after the pin rises
    bus.replay_btn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("press_lat2", 64'(bus.running), 64'(0));
    @(negedge clk);
    check("press_lat3", 64'(bus.running), 64'(1));
    bus.replay_btn = 1'b0;

    // Two ticks of motion
    wait_tick("tick1");
    t1 = tick_cyc;
    model_tick(n);
    wait_tick("tick2");
    check("tick_spacing", 64'(tick_cyc - t1), 64'(4));
    model_tick(n);
    check("motion_s_cac", 64'(bus.obs_x[10:0]),  64'(1198));
    check("motion_ptr",   64'(bus.obs_x[43:33]), 64'(1398));
    check("motion_anim",  64'(bus.anim_phase),   64'(2));
    check("motion_run",   64'(bus.running),      64'(1));

    // Run until s_cac sits at 1 (tick 1199)
    for (int i = 0; i < 1197; i++) begin
      wait_tick("run_tick");
      model_tick(n);
    end
    check("pre_exp_s_cac", 64'(bus.obs_x[10:0]), 64'(1));
    check("pre_exp_score", 64'(bus.score),       64'(0));

    // Tick 1200: s_cac expires
    wait_tick("exp_tick");
    model_tick(n);
    check("exp_s_cac", 64'(bus.obs_x[10:0]), 64'(0));
    check("exp_score", 64'(bus.score),       64'(1));

    // Tick 1201: respawn; LFSR after 1200 advances is 6'b011111 -> cand 1520
    wait_tick("resp_tick");
    model_tick(n);
    check("resp_s_cac", 64'(bus.obs_x[10:0]),  64'(1520));
    check("resp_group", 64'(bus.obs_x[21:11]), 64'(399));
    check("resp_lava",  64'(bus.obs_x[32:22]), 64'(599));
    check("resp_ptr",   64'(bus.obs_x[43:33]), 64'(199));
    check("resp_model", 64'(bus.obs_x),        64'(model_obs()));

    // Collision coincident with a tick: tick discarded, enter OVER
    k = 0;
    while (bus.tick !== 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    check("col_tick_seen", 64'(bus.tick), 64'(1));
    bus.collision = 1'b1;
    @(negedge clk);
    bus.collision = 1'b0;
    check("col_over",    64'(bus.game_over),  64'(1));
    check("col_running", 64'(bus.running),    64'(0));
    check("col_obs",     64'(bus.obs_x),      64'(model_obs()));
    check("col_anim",    64'(bus.anim_phase), 64'(manim));
    check("col_score",   64'(bus.score),      64'(mscore));
    ticks_seen = 0;
    bad        = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) ticks_seen++;
      if (bus.obs_x !== model_obs()) bad++;
    end
    check("over_ticks",  64'(ticks_seen),    64'(0));
    check("over_frozen", 64'(bad),           64'(0));
    check("over_held",   64'(bus.game_over), 64'(1));

    // Held replay press restarts once; LFSR continues
    bus.replay_btn = 1'b1;
    k = 0;
    while (bus.running !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("replay_run",   64'(bus.running),    64'(1));
    check("replay_obs",   64'(bus.obs_x),      64'(init_obs));
    check("replay_score", 64'(bus.score),      64'(0));
    check("replay_speed", 64'(bus.speed),      64'(1));
    check("replay_anim",  64'(bus.anim_phase), 64'(0));
    model_init();
    for (int i = 0; i < 4; i++) model_step("replay_hold", n);
    bus.replay_btn = 1'b0;

    // Long run through the speed ramp to saturation
    first12_done = 1'b0;
    exp_at_max   = 0;
    nt           = 0;
    while (nt < 20000 && errors == 0 && !(mspeed == 8 && exp_at_max >= 12)) begin
      was_max = (mspeed == 8);
      model_step("ramp", n);
      nt++;
      if (was_max) exp_at_max += n;
      if (!first12_done && mscore >= 12) begin
        first12_done = 1'b1;
        check("speed_step12", 64'(bus.speed), 64'(2));
      end
    end
    check("speed_sat", 64'(bus.speed),      64'(8));
    check("ramp_anim", 64'(bus.anim_phase), 64'(manim));

    // Press coincident with collision in RUN: OVER wins
    bus.replay_btn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.collision = 1'b1;
    @(negedge clk);
    bus.collision  = 1'b0;
    bus.replay_btn = 1'b0;
    check("presscol_over", 64'(bus.game_over), 64'(1));
    check("presscol_run",  64'(bus.running),   64'(0));
    check("presscol_obs",  64'(bus.obs_x),     64'(model_obs()));
    repeat (10) @(negedge clk);
    check("presscol_held", 64'(bus.game_over), 64'(1));

    // Restart, move two ticks, then async reset between edges
    bus.replay_btn = 1'b1;
    k = 0;
    while (bus.running !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    bus.replay_btn = 1'b0;
    check("restart_run", 64'(bus.running), 64'(1));
    model_init();
    model_step("restart", n);
    model_step("restart", n);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_obs",       64'(bus.obs_x),      64'(init_obs));
    check("arst_running",   64'(bus.running),    64'(0));
    check("arst_game_over", 64'(bus.game_over),  64'(0));
    check("arst_speed",     64'(bus.speed),      64'(1));
    check("arst_score",     64'(bus.score),      64'(0));
    check("arst_anim",      64'(bus.anim_phase), 64'(0));
    check("arst_tick",      64'(bus.tick),       64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_run",  64'(bus.running),   64'(0));
    check("post_rst_over", 64'(bus.game_over), 64'(0));
    check("post_rst_obs",  64'(bus.obs_x),     64'(init_obs));
    check("post_rst_tick", 64'(bus.tick),      64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
